// File: rtl/ebus_diag_pkg.sv
// ebus_diag_pkg: shared types and helpers for the EBUS diagnostic initiator.
//   diag_state_t       - sequencer states
//   DIAG_FUNC_READ_BIT - index of ds[0]; set means a read function (1xx octal)
//   DIAG_CTL_01X       - base of the CON 01x control-strobe group
//   odd_par36()        - odd parity bit for a 36-bit EBUS word
package ebus_diag_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        SETTLE = 3'd4,
        RESP   = 3'd5
    } diag_state_t;

    localparam int         DIAG_FUNC_READ_BIT = 0;
    localparam logic [0:6] DIAG_CTL_01X       = 7'o010;

    // Bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_par36(input logic [0:35] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ebus_diag_master_if.sv
// ebus_diag_master_if: command/response handshake and EBUS signals of the
// diagnostic initiator.
//   master modport - the initiator (drives cmd_ready, rsp_*, ebus_* outputs)
//   slave modport  - front-end plus EBOX side (drives cmd_*, rsp_ready, ebus_data_in/parity_in)
interface ebus_diag_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:6]  cmd_func;
    logic [0:35] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:35] rsp_data;
    logic        rsp_par_err;
    logic [0:6]  ebus_ds;
    logic        ebus_diag_strobe;
    logic        ebus_diag_read;
    logic        ebus_data_oe;
    logic [0:35] ebus_data_out;
    logic        ebus_parity_out;
    logic [0:35] ebus_data_in;
    logic        ebus_parity_in;

    modport master (
        input  cmd_valid, cmd_func, cmd_data, rsp_ready, ebus_data_in, ebus_parity_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_par_err, ebus_ds, ebus_diag_strobe,
               ebus_diag_read, ebus_data_oe, ebus_data_out, ebus_parity_out
    );

    modport slave (
        output cmd_valid, cmd_func, cmd_data, rsp_ready, ebus_data_in, ebus_parity_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_par_err, ebus_ds, ebus_diag_strobe,
               ebus_diag_read, ebus_data_oe, ebus_data_out, ebus_parity_out
    );

endinterface

// File: rtl/ebus_diag_timer.sv
// ebus_diag_timer: 3-bit loadable down-counter shared by the SETUP, STROBE
// and SETTLE phases.
//   clk, reset_n - clock, synchronous active-low reset
//   load, value  - load the count with value (loaded on the edge entering a phase)
//   expire       - high during the last cycle of the loaded phase (count == 1)
module ebus_diag_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [2:0] value,
    output logic       expire
);

    logic [2:0] count_r;

    // Count down to zero and park there until reloaded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= 3'd0;
        end else if (load) begin
            count_r <= value;
        end else if (count_r != 3'd0) begin
            count_r <= count_r - 3'd1;
        end else begin
            count_r <= 3'd0;
        end
    end

    assign expire = (count_r == 3'd1);

endmodule

// File: rtl/ebus_diag_master.sv
// ebus_diag_master: console-side EBUS diagnostic initiator. Writes/controls
// (ds[0]=0) are strobed into the target; reads (ds[0]=1) hold diag_read and
// sample the returned word into the response.
//   clk, reset_n - clock, synchronous active-low reset
//   bus          - ebus_diag_master_if.master (command, response and EBUS signals)
// Parameters: SETUP_CYC, STROBE_CYC, READ_SETTLE (each 1..7 cycles).
// Optional macro EBUS_DIAG_PARITY_EN: drives odd write parity and checks read
// parity; without it ebus_parity_out and rsp_par_err are tied 0.
// All outputs are registered, computed from the next state.
module ebus_diag_master
    import ebus_diag_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int READ_SETTLE = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    ebus_diag_master_if.master  bus
);

    diag_state_t state_r, state_next;
    logic [0:6]  func_r;
    logic [0:35] data_r;
    logic        read_r;
    logic        tmr_load, tmr_expire, accept, capture;
    logic [2:0]  tmr_value;

    logic [0:6]  cur_func, ds_next, ds_r;
    logic [0:35] cur_data, dout_next, dout_r, rsp_data_r;
    logic        cur_read, strobe_next, rd_next, oe_next;
    logic        strobe_r, rd_r, oe_r, cmd_ready_r, rsp_valid_r;

    ebus_diag_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .expire  (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state decode and timer loading.
    always_comb begin
        state_next = state_r;
        tmr_load   = 1'b0;
        tmr_value  = 3'd0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = 3'(SETUP_CYC);
                end else begin
                    state_next = IDLE;
                end
            end
            SETUP: begin
                if (tmr_expire && read_r) begin
                    state_next = SETTLE;
                    tmr_load   = 1'b1;
                    tmr_value  = 3'(READ_SETTLE);
                end else if (tmr_expire) begin
                    state_next = STROBE;
                    tmr_load   = 1'b1;
                    tmr_value  = 3'(STROBE_CYC);
                end else begin
                    state_next = SETUP;
                end
            end
            STROBE: begin
                if (tmr_expire) begin
                    state_next = HOLD;
                end else begin
                    state_next = STROBE;
                end
            end
            HOLD: begin
                state_next = RESP;
            end
            SETTLE: begin
                if (tmr_expire) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = SETTLE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end else begin
                    state_next = RESP;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // EBUS output values for the coming cycle; in IDLE the command is not yet
    // latched, so the incoming one is used directly.
    always_comb begin
        cur_func    = (state_r == IDLE) ? bus.cmd_func : func_r;
        cur_data    = (state_r == IDLE) ? bus.cmd_data : data_r;
        cur_read    = (state_r == IDLE) ? bus.cmd_func[DIAG_FUNC_READ_BIT] : read_r;
        ds_next     = 7'd0;
        dout_next   = 36'd0;
        strobe_next = 1'b0;
        rd_next     = 1'b0;
        oe_next     = 1'b0;
        case (state_next)
            SETUP: begin
                ds_next   = cur_func;
                oe_next   = ~cur_read;
                dout_next = cur_read ? 36'd0 : cur_data;
            end
            STROBE: begin
                ds_next     = cur_func;
                oe_next     = 1'b1;
                dout_next   = cur_data;
                strobe_next = 1'b1;
            end
            HOLD: begin
                ds_next   = cur_func;
                oe_next   = 1'b1;
                dout_next = cur_data;
            end
            SETTLE: begin
                ds_next = cur_func;
                rd_next = 1'b1;
            end
            default: begin
                ds_next = 7'd0;
            end
        endcase
    end

    // Latched command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            func_r <= 7'd0;
            data_r <= 36'd0;
            read_r <= 1'b0;
        end else if (accept) begin
            func_r <= bus.cmd_func;
            data_r <= bus.cmd_data;
            read_r <= bus.cmd_func[DIAG_FUNC_READ_BIT];
        end else begin
            func_r <= func_r;
            data_r <= data_r;
            read_r <= read_r;
        end
    end

    // Registered outputs and response word; rsp_data is cleared once taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            ds_r        <= 7'd0;
            dout_r      <= 36'd0;
            strobe_r    <= 1'b0;
            rd_r        <= 1'b0;
            oe_r        <= 1'b0;
            rsp_data_r  <= 36'd0;
        end else begin
            cmd_ready_r <= (state_next == IDLE);
            rsp_valid_r <= (state_next == RESP);
            ds_r        <= ds_next;
            dout_r      <= dout_next;
            strobe_r    <= strobe_next;
            rd_r        <= rd_next;
            oe_r        <= oe_next;
            if (accept) begin
                rsp_data_r <= 36'd0;
            end else if (capture) begin
                rsp_data_r <= bus.ebus_data_in;
            end else if ((state_r == RESP) && bus.rsp_ready) begin
                rsp_data_r <= 36'd0;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

`ifdef EBUS_DIAG_PARITY_EN
    logic par_out_r, par_err_r;

    // Write parity follows the driven word; read parity error is captured with the data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_out_r <= 1'b0;
            par_err_r <= 1'b0;
        end else begin
            par_out_r <= oe_next ? odd_par36(dout_next) : 1'b0;
            if (accept) begin
                par_err_r <= 1'b0;
            end else if (capture) begin
                par_err_r <= (odd_par36(bus.ebus_data_in) != bus.ebus_parity_in);
            end else if ((state_r == RESP) && bus.rsp_ready) begin
                par_err_r <= 1'b0;
            end else begin
                par_err_r <= par_err_r;
            end
        end
    end

    assign bus.ebus_parity_out = par_out_r;
    assign bus.rsp_par_err     = par_err_r;
`else
    assign bus.ebus_parity_out = 1'b0;
    assign bus.rsp_par_err     = 1'b0;
`endif

    assign bus.cmd_ready        = cmd_ready_r;
    assign bus.rsp_valid        = rsp_valid_r;
    assign bus.rsp_data         = rsp_data_r;
    assign bus.ebus_ds          = ds_r;
    assign bus.ebus_diag_strobe = strobe_r;
    assign bus.ebus_diag_read   = rd_r;
    assign bus.ebus_data_oe     = oe_r;
    assign bus.ebus_data_out    = dout_r;

endmodule
